// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the fetch stage: state encoding,
// the bubble instruction and the default boot address.
package fetch_stage_pkg;

    typedef enum logic [1:0] {
        S_EMPTY = 2'b00,
        S_READ  = 2'b01,
        S_HOLD  = 2'b10
    } fetch_state_t;

    localparam logic [31:0] NOP_INST         = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Sequential next PC; wraps modulo 2^32.
    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

    // Force a byte address onto a word boundary.
    function automatic logic [31:0] word_align(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage.sv
// Front pipeline stage: owns the PC, issues reads to a 1-cycle-latency
// instruction memory and parks the returned word in a one-entry skid
// register while decode is stalled. A flush redirects to redirect_pc.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC       = DEFAULT_RESET_PC,
    parameter int          IMEM_ADDR_BITS = 11
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      decode_stall,
    input  logic                      decode_flush,
    input  logic [31:0]               redirect_pc,
    output logic                      imem_en,
    output logic [IMEM_ADDR_BITS-1:0] imem_addr,
    input  logic [31:0]               imem_rdata,
    output logic [31:0]               fetch_pc,
    output logic [31:0]               fetch_inst,
    output logic                      fetch_valid
);

    logic [31:0]  issue_pc_q,  issue_pc_d;
    logic [31:0]  rd_pc_q,     rd_pc_d;
    logic [31:0]  skid_pc_q,   skid_pc_d;
    logic [31:0]  skid_inst_q, skid_inst_d;
    fetch_state_t state_q,     state_d;

    // Byte address handed to memory this cycle; only the word bits leave.
    logic [31:0]  imem_pc;
    logic         imem_req;
    logic [31:0]  target_pc;

    assign target_pc = word_align(redirect_pc);

    // Present the instruction selected by the current state (no path from stall/flush).
    always_comb begin
        fetch_valid = 1'b0;
        fetch_pc    = 32'h0;
        fetch_inst  = NOP_INST;
        case (state_q)
            S_HOLD: begin
                fetch_valid = 1'b1;
                fetch_pc    = skid_pc_q;
                fetch_inst  = skid_inst_q;
            end
            S_READ: begin
                fetch_valid = 1'b1;
                fetch_pc    = rd_pc_q;
                fetch_inst  = imem_rdata;
            end
            default: begin
                fetch_valid = 1'b0;
                fetch_pc    = 32'h0;
                fetch_inst  = NOP_INST;
            end
        endcase
    end

    // Next-state and memory request: flush beats stall beats advance.
    always_comb begin
        issue_pc_d  = issue_pc_q;
        rd_pc_d     = rd_pc_q;
        skid_pc_d   = skid_pc_q;
        skid_inst_d = skid_inst_q;
        state_d     = state_q;
        imem_req    = 1'b0;
        imem_pc     = issue_pc_q;

        if (decode_flush) begin
            imem_req    = 1'b1;
            imem_pc     = target_pc;
            rd_pc_d     = target_pc;
            issue_pc_d  = pc_plus4(target_pc);
            state_d     = S_READ;
            skid_pc_d   = 32'h0;
            skid_inst_d = NOP_INST;
        end else if (decode_stall) begin
            case (state_q)
                // Memory output may change after this cycle, so grab it now.
                S_READ: begin
                    skid_pc_d   = rd_pc_q;
                    skid_inst_d = imem_rdata;
                    state_d     = S_HOLD;
                end
                S_HOLD:  state_d = S_HOLD;
                S_EMPTY: state_d = S_EMPTY;
                default: state_d = S_EMPTY;
            endcase
        end else begin
            imem_req   = 1'b1;
            imem_pc    = issue_pc_q;
            rd_pc_d    = issue_pc_q;
            issue_pc_d = pc_plus4(issue_pc_q);
            state_d    = S_READ;
        end
    end

    // Requests are suppressed while reset is held so memory sees nothing.
    assign imem_en   = imem_req & i_reset;
    assign imem_addr = imem_pc[IMEM_ADDR_BITS+1:2];

    // Address bits that memory never sees, collected only to keep them tidy.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{imem_pc[31:IMEM_ADDR_BITS+2], imem_pc[1:0], redirect_pc[1:0]};

    // State registers; reset drops straight to the bubble.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            issue_pc_q  <= RESET_PC;
            rd_pc_q     <= 32'h0;
            skid_pc_q   <= 32'h0;
            skid_inst_q <= NOP_INST;
            state_q     <= S_EMPTY;
        end else begin
            issue_pc_q  <= issue_pc_d;
            rd_pc_q     <= rd_pc_d;
            skid_pc_q   <= skid_pc_d;
            skid_inst_q <= skid_inst_d;
            state_q     <= state_d;
        end
    end

endmodule
